imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 135 +++++++++++++
 tb/tb_imem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory with fixed-latency, strictly in-order fetch responses and a program-load write port.
// Optional macro IMEM_RESPONDER_FLUSH_EN adds a redirect flush that discards every outstanding response.
module imem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH_WORDS   = 256,
  parameter int LATENCY       = 2,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_instr,
  output logic [ADDRESS_WIDTH-1:0] rsp_addr,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [1:0]            WAIT_INIT = 2'(LATENCY - 1);
  localparam logic [PTR_W-1:0]      LAST_SLOT = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Every accepted request owns one response slot from acceptance until it is consumed,
  // so the slot ring doubles as the latency pipeline: a slot becomes visible once its wait hits zero.
  logic [DATA_WIDTH-1:0]    instr_q [RSP_DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_q  [RSP_DEPTH];
  logic                     err_q   [RSP_DEPTH];
  logic [1:0]               wait_q  [RSP_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_slot;
  logic [CNT_W-1:0] count_q, count_d;

  logic                  accept, consume;
  logic                  req_misaligned, req_out_of_range, req_err;
  logic [DATA_WIDTH-1:0] req_instr;
  logic                  wr_in_range;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign req_misaligned   = |req_addr[1:0];
  assign req_out_of_range = |req_addr[ADDRESS_WIDTH-1:IDX_W+2];
  assign req_err          = req_misaligned | req_out_of_range;
  assign req_instr        = req_err ? NOP : mem[req_addr[2 +: IDX_W]];
  assign wr_in_range      = ~|wr_addr[ADDRESS_WIDTH-1:IDX_W+2];

  assign req_ready = rst && (count_q < FULL_CNT);
  assign rsp_valid = (count_q != '0) && (wait_q[rd_ptr_q] == 2'd0);
  assign rsp_instr = rsp_valid ? instr_q[rd_ptr_q] : '0;
  assign rsp_addr  = rsp_valid ? addr_q[rd_ptr_q]  : '0;
  assign rsp_err   = rsp_valid && err_q[rd_ptr_q];

  assign accept  = req_valid && req_ready;
  assign consume = rsp_valid && rsp_ready;

  logic unused_wr_lsb;
  assign unused_wr_lsb = ^wr_addr[1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_slot  = wr_ptr_q;
    count_d  = count_q;
    if (consume) rd_ptr_d = next_ptr(rd_ptr_q);
    if (accept)  wr_ptr_d = next_ptr(wr_ptr_q);
    case ({accept, consume})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
`ifdef IMEM_RESPONDER_FLUSH_EN
    // A redirect empties the ring; a request taken on the same edge restarts it at slot 0.
    if (flush) begin
      rd_ptr_d = '0;
      wr_slot  = '0;
      wr_ptr_d = accept ? next_ptr('0) : '0;
      count_d  = accept ? CNT_W'(1) : '0;
    end
`endif
  end

`ifndef IMEM_RESPONDER_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        instr_q[i] <= '0;
        addr_q[i]  <= '0;
        err_q[i]   <= 1'b0;
        wait_q[i]  <= 2'd0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        if (wait_q[i] != 2'd0) wait_q[i] <= wait_q[i] - 1'b1;
      end
      if (accept) begin
        instr_q[wr_slot] <= req_instr;
        addr_q[wr_slot]  <= req_addr;
        err_q[wr_slot]   <= req_err;
        wait_q[wr_slot]  <= WAIT_INIT;
      end
    end
  end

  // Program memory is deliberately not reset; the read above sees the pre-write word on a same-edge write.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) mem[wr_addr[2 +: IDX_W]] <= wr_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a timestamped queue model predicts every response and handshake.
module tb_imem_responder;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int WORDS = 256;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        flush;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic        err;
      int          acc;
   } expItem;

   expItem      expQ[$];
   logic [31:0] modelMem [WORDS];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   imem_responder #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_WORDS(WORDS),
      .LATENCY(LAT), .RSP_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // Free-running clock; posedges are numbered by cyc so responses can be timestamped
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, then wait out that cycle
   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr,
                                input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                input logic fl);
      req_valid = v;
      req_addr  = a;
      rsp_ready = rr;
      wr_en     = we;
      wr_addr   = wa;
      wr_data   = wd;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   function automatic expItem modelRead(input logic [31:0] a, input int accEdge);
      expItem it;
      it.addr = a;
      it.acc  = accEdge;
      if (a[1:0] != 2'b00 || a >= 32'(4 * WORDS)) begin
         it.err   = 1'b1;
         it.instr = 32'h0000_0013;
      end else begin
         it.err   = 1'b0;
         it.instr = modelMem[a[9:2]];
      end
      return it;
   endfunction

   // Monitor: compare what the DUT shows this cycle, then advance the model across the coming edge
   always @(negedge clk) begin
      logic expValid;
      logic expReady;
      logic doPush;
      logic doPop;
      if (!rst) begin
         checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
         checkOutput("reset_rsp_instr", rsp_instr, 32'd0);
         checkOutput("reset_rsp_addr", rsp_addr, 32'd0);
         checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
         expQ.delete();
      end else begin
         expValid = (expQ.size() != 0) && (cyc >= expQ[0].acc + LAT - 1);
         expReady = (expQ.size() < DEPTH);
         checkOutput("req_ready", 32'(req_ready), 32'(expReady));
         checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
         if (expValid && rsp_valid) begin
            checkOutput("rsp_instr", rsp_instr, expQ[0].instr);
            checkOutput("rsp_addr", rsp_addr, expQ[0].addr);
            checkOutput("rsp_err", 32'(rsp_err), 32'(expQ[0].err));
         end
         doPop  = expValid && rsp_ready;
         doPush = req_valid && expReady;
         if (doPop) void'(expQ.pop_front());
`ifdef IMEM_RESPONDER_FLUSH_EN
         if (flush) expQ.delete();
`endif
         if (doPush) expQ.push_back(modelRead(req_addr, cyc + 1));
         if (wr_en && wr_addr < 32'(4 * WORDS)) modelMem[wr_addr[9:2]] = wr_data;
      end
   end

   // Directed scenarios first, then a long randomized run, then reset-in-flight and a final drain
   initial begin
      logic [31:0] a;
      int          r;
      req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
      wr_en = 0; wr_addr = 0; wr_data = 0;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < WORDS; i++)
         applyStimulus(0, 0, 1, 1, 32'(i * 4), (i == 3) ? 32'h0050_0093 : $urandom, 0);
      applyStimulus(1, 32'h0000_000C, 1, 0, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      for (int i = 0; i < 4; i++) applyStimulus(1, 32'(i * 4), 1, 0, 0, 0, 0);
      repeat (4) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      for (int i = 0; i < 8; i++) applyStimulus(1, 32'(16 + i * 4), 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(1, 32'(64 + i * 4), 1, 0, 0, 0, 0);
      repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      applyStimulus(1, 32'h0000_0002, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0400, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_03FC, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0401, 1, 1, 32'h0000_0400, 32'hDEAD_BEEF, 0);
      applyStimulus(1, 32'h0000_0010, 1, 1, 32'h0000_0010, 32'h1234_5678, 0);
      applyStimulus(1, 32'h0000_0010, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0000, 1, 0, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      for (int i = 0; i < 3; i++) applyStimulus(1, 32'(i * 4), 0, 0, 0, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0040, 0, 0, 0, 0, 1);
      repeat (8) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      for (int n = 0; n < 1500; n++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0)      a = {22'($urandom), 8'($urandom), 2'($urandom_range(1, 3))};
         else if (r == 1) a = 32'h0000_0400 + {20'($urandom), 2'b00};
         else             a = {22'd0, 8'($urandom), 2'b00};
         applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 9) < 7,
                       $urandom_range(0, 15) == 0, {20'd0, 10'($urandom), 2'b00}, $urandom,
                       $urandom_range(0, 63) == 0);
      end
      repeat (8) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      applyStimulus(1, 32'h0000_0020, 0, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_0024, 0, 0, 0, 0, 0);
      req_valid = 0;
      #2 rst = 1'b0;
      #1 checkOutput("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 32'h0000_000C, 1, 0, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);

      checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
